// File: rtl/bilinear_calc.sv
// Bilinear interpolator: blends a 2x2 neighbour quad using fixed-point x/y fractions and tags the frame/line position.
// Latency: 3 cycles from tvalid_i to tvalid_o, one quad per cycle, and gaps in the input pass through unchanged.
// No backpressure: tready_i is only monitored, and an output dropped by downstream sets the sticky overflow_o flag.
module bilinear_calc #(
  parameter int DATA_WIDTH = 8,
  parameter int FIX_WIDTH  = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tvalid_i,
  input  logic [DATA_WIDTH-1:0] tdata00_i,
  input  logic [DATA_WIDTH-1:0] tdata01_i,
  input  logic [DATA_WIDTH-1:0] tdata10_i,
  input  logic [DATA_WIDTH-1:0] tdata11_i,
  input  logic [FIX_WIDTH-1:0]  fracx_i,
  input  logic [FIX_WIDTH-1:0]  fracy_i,
  input  logic [15:0]           dest_width_i,
  input  logic [15:0]           dest_height_i,
  output logic                  tvalid_o,
  output logic [DATA_WIDTH-1:0] tdata_o,
  output logic                  tlast_o,
  output logic                  tuser_o,
  input  logic                  tready_i,
  output logic                  overflow_o
);

  localparam int WW = FIX_WIDTH + 1;                  // weight width, holds 2^FIX_WIDTH
  localparam int HW = DATA_WIDTH + FIX_WIDTH + 1;     // horizontal blend width
  localparam int VW = DATA_WIDTH + 2*FIX_WIDTH + 2;   // vertical blend width

  localparam logic [WW-1:0] W_ONE = {1'b1, {FIX_WIDTH{1'b0}}};
  localparam logic [VW-1:0] RND   = VW'(1) << (2*FIX_WIDTH - 1);

  logic [WW-1:0] wx0, wx1, wy0, wy1;
  logic [WW-1:0] wy0_q, wy1_q;
  logic [HW-1:0] h0_q, h1_q;
  logic [VW-1:0] v_q;
  logic [VW-1:0] rnd;
  logic [VW-1:0] rnd_sh;
  logic [DATA_WIDTH-1:0] pix;
  logic          v1_q, v2_q;
  logic [15:0]   x_cnt, y_cnt;

  assign wx1 = {1'b0, fracx_i};
  assign wx0 = W_ONE - wx1;
  assign wy1 = {1'b0, fracy_i};
  assign wy0 = W_ONE - wy1;

  // Round half up, then clamp anything above the pixel range to full scale.
  assign rnd    = v_q + RND;
  assign rnd_sh = rnd >> (2*FIX_WIDTH);
  assign pix    = (|rnd_sh[VW-1:DATA_WIDTH]) ? {DATA_WIDTH{1'b1}} : rnd_sh[DATA_WIDTH-1:0];

  // Stage 1: horizontal blends of the top and bottom rows; the y weights ride along.
  always_ff @(posedge clk_i) begin
    if (rst_i) v1_q <= 1'b0;
    else       v1_q <= tvalid_i;
    h0_q  <= HW'(tdata00_i) * HW'(wx0) + HW'(tdata01_i) * HW'(wx1);
    h1_q  <= HW'(tdata10_i) * HW'(wx0) + HW'(tdata11_i) * HW'(wx1);
    wy0_q <= wy0;
    wy1_q <= wy1;
  end

  // Stage 2: vertical blend kept at full precision.
  always_ff @(posedge clk_i) begin
    if (rst_i) v2_q <= 1'b0;
    else       v2_q <= v1_q;
    v_q <= VW'(h0_q) * VW'(wy0_q) + VW'(h1_q) * VW'(wy1_q);
  end

  // Stage 3: registered output, data forced to zero on idle cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tvalid_o <= 1'b0;
      tdata_o  <= '0;
    end else begin
      tvalid_o <= v2_q;
      tdata_o  <= v2_q ? pix : '0;
    end
  end

  // Position counters describe the pixel currently on tdata_o and step past it once it is shown.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (tvalid_o) begin
      if (x_cnt == dest_width_i - 16'd1) begin
        x_cnt <= '0;
        if (y_cnt == dest_height_i - 16'd1) y_cnt <= '0;
        else                                y_cnt <= y_cnt + 16'd1;
      end else begin
        x_cnt <= x_cnt + 16'd1;
      end
    end
  end

  // Sticky flag: downstream was not ready for a pixel we could not hold back.
  always_ff @(posedge clk_i) begin
    if (rst_i)                     overflow_o <= 1'b0;
    else if (tvalid_o && !tready_i) overflow_o <= 1'b1;
  end

  assign tlast_o = tvalid_o && (x_cnt == dest_width_i - 16'd1);
  assign tuser_o = tvalid_o && (x_cnt == 16'd0) && (y_cnt == 16'd0);

endmodule

// File: tb/tb_bilinear_calc.sv
module tb_bilinear_calc;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        tvalid_i;
  logic [7:0]  tdata00_i, tdata01_i, tdata10_i, tdata11_i;
  logic [11:0] fracx_i, fracy_i;
  logic [15:0] dest_width_i, dest_height_i;
  logic        tvalid_o;
  logic [7:0]  tdata_o;
  logic        tlast_o, tuser_o;
  logic        tready_i;
  logic        overflow_o;

  always #5 clk_i = ~clk_i;

  bilinear_calc #(.DATA_WIDTH(8), .FIX_WIDTH(12)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tvalid_i(tvalid_i),
    .tdata00_i(tdata00_i), .tdata01_i(tdata01_i), .tdata10_i(tdata10_i), .tdata11_i(tdata11_i),
    .fracx_i(fracx_i), .fracy_i(fracy_i),
    .dest_width_i(dest_width_i), .dest_height_i(dest_height_i),
    .tvalid_o(tvalid_o), .tdata_o(tdata_o), .tlast_o(tlast_o), .tuser_o(tuser_o),
    .tready_i(tready_i), .overflow_o(overflow_o)
  );

  typedef struct {
    logic [7:0]  p00, p01, p10, p11;
    logic [11:0] fx, fy;
    logic [7:0]  exp;
  } vec_t;

  typedef struct {
    logic [7:0] dat;
    logic       last;
    logic       user;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  vec_t tbl[12];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   in_idx = 0;
  int   burst = 0, last_out = -10;
  logic mon_en = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Drive one quad for one cycle and push its expected output.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] d, input logic [11:0] fx, input logic [11:0] fy,
                      input logic [7:0] ex);
    int w, h;
    exp_t t;
    w = int'(dest_width_i);
    h = int'(dest_height_i);
    tdata00_i = a; tdata01_i = b; tdata10_i = c; tdata11_i = d;
    fracx_i = fx; fracy_i = fy; tvalid_i = 1'b1;
    t.dat  = ex;
    t.last = ((in_idx % w) == w - 1);
    t.user = ((in_idx % (w * h)) == 0);
    t.cyc  = cyc + 3;
    sb.push_back(t);
    in_idx++;
    idle(1);
    tvalid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      idle(1);
      n++;
    end
    if (sb.size() > 0) check("drain_timeout", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    sb.delete();
    in_idx = 0;
    idle(2);
    rst_i = 1'b0;
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (tvalid_o) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("tdata", tdata_o, e.dat);
          check("tlast", tlast_o, e.last);
          check("tuser", tuser_o, e.user);
          check("latency_cycle", cyc, e.cyc);
        end
        if (cyc == last_out + 1) burst++;
        else                     burst = 1;
        last_out = cyc;
      end else begin
        check("idle_outputs_zero", {tdata_o, tlast_o, tuser_o}, 0);
      end
    end
  end

  initial begin
    tbl[0]  = '{8'd100, 8'd0,   8'd0,   8'd0,   12'd0,    12'd0,    8'd100};
    tbl[1]  = '{8'd0,   8'd255, 8'd0,   8'd255, 12'd2048, 12'd0,    8'd128};
    tbl[2]  = '{8'd255, 8'd255, 8'd255, 8'd255, 12'd4095, 12'd4095, 8'd255};
    tbl[3]  = '{8'd0,   8'd0,   8'd0,   8'd0,   12'd1234, 12'd567,  8'd0};
    tbl[4]  = '{8'd200, 8'd100, 8'd50,  8'd0,   12'd2048, 12'd2048, 8'd88};
    tbl[5]  = '{8'd10,  8'd20,  8'd0,   8'd0,   12'd1024, 12'd0,    8'd13};
    tbl[6]  = '{8'd0,   8'd0,   8'd255, 8'd255, 12'd0,    12'd4095, 8'd255};
    tbl[7]  = '{8'd100, 8'd100, 8'd100, 8'd100, 12'd777,  12'd3000, 8'd100};
    tbl[8]  = '{8'd1,   8'd0,   8'd0,   8'd0,   12'd2048, 12'd2048, 8'd0};
    tbl[9]  = '{8'd2,   8'd0,   8'd0,   8'd0,   12'd2048, 12'd2048, 8'd1};
    tbl[10] = '{8'd3,   8'd0,   8'd0,   8'd0,   12'd2048, 12'd2048, 8'd1};
    tbl[11] = '{8'd0,   8'd0,   8'd0,   8'd255, 12'd4095, 12'd4095, 8'd255};

    rst_i = 1'b1; tvalid_i = 1'b0; tready_i = 1'b1;
    tdata00_i = '0; tdata01_i = '0; tdata10_i = '0; tdata11_i = '0;
    fracx_i = '0; fracy_i = '0;
    dest_width_i = 16'd4; dest_height_i = 16'd2;
    idle(3);
    rst_i = 1'b0;
    check("reset_tvalid", tvalid_o, 0);
    check("reset_tdata", tdata_o, 0);
    check("reset_overflow", overflow_o, 0);
    mon_en = 1'b1;

    // Single pulse: 3-cycle latency, first pixel of frame.
    send(8'd100, 8'd0, 8'd0, 8'd0, 12'd0, 12'd0, 8'd100);
    drain();

    // Table of arithmetic cases on a 3x2 frame, with occasional input gaps.
    dest_width_i = 16'd3; dest_height_i = 16'd2;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].p00, tbl[i].p01, tbl[i].p10, tbl[i].p11, tbl[i].fx, tbl[i].fy, tbl[i].exp);
      if (i % 4 == 3) idle(1);
    end
    drain();

    // Single-pixel lines: every output is a line end.
    dest_width_i = 16'd1; dest_height_i = 16'd3;
    do_reset();
    for (int i = 0; i < 4; i++) send(8'(i * 7), 8'(i * 7), 8'(i * 7), 8'(i * 7), 12'd99, 12'd4000, 8'(i * 7));
    drain();

    // 4x2 frame with 10 continuous inputs: wrap into the next frame, unbroken burst.
    dest_width_i = 16'd4; dest_height_i = 16'd2;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(8'(i * 10), 8'(i * 10), 8'(i * 10), 8'(i * 10),
           12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 8'(i * 10));
    end
    drain();
    check("burst_length", burst, 10);

    // Reset lands while three quads are in flight: none of them may appear.
    do_reset();
    send(8'd11, 8'd11, 8'd11, 8'd11, 12'd0, 12'd0, 8'd11);
    send(8'd22, 8'd22, 8'd22, 8'd22, 12'd0, 12'd0, 8'd22);
    rst_i = 1'b1;
    send(8'd33, 8'd33, 8'd33, 8'd33, 12'd0, 12'd0, 8'd33);
    sb.delete();
    in_idx = 0;
    idle(1);
    rst_i = 1'b0;
    idle(5);
    send(8'd44, 8'd44, 8'd44, 8'd44, 12'd0, 12'd0, 8'd44);
    drain();

    // Downstream stall for one output sets the sticky overflow flag.
    send(8'd50, 8'd50, 8'd50, 8'd50, 12'd0, 12'd0, 8'd50);
    idle(2);
    check("overflow_before_drop", overflow_o, 0);
    tready_i = 1'b0;
    idle(1);
    tready_i = 1'b1;
    check("overflow_after_drop", overflow_o, 1);
    for (int i = 0; i < 5; i++) send(8'd60, 8'd70, 8'd80, 8'd90, 12'd0, 12'd0, 8'd60);
    drain();
    check("overflow_sticky", overflow_o, 1);
    do_reset();
    check("overflow_cleared", overflow_o, 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
